alu_mdu_ctrl: RTL and testbench

- Next-generation ALU control for the EX stage.
- Keeps the combinational ALU opcode / operand-select decode and adds a fourth operation class (i_operation = 2'b11) for multiply/divide.
- That class drives an iterative, parametrised multiply/divide unit with HI/LO registers and a pipeline stall handshake.
- Sits between the main control unit and the ALU and ID/EX pipeline registers.

---
 rtl/alu_mdu_ctrl_if.sv | 34 +++
 rtl/alu_mdu_ctrl.sv | 123 ++++++++++++
 tb/tb_alu_mdu_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_mdu_ctrl_if.sv
// alu_mdu_ctrl_if: EX-stage control bus between the pipeline and alu_mdu_ctrl.
// Ports: master drives i_* (valid, operation class, funct, rs/rt operands) and
// samples o_* (ALU decode, stall/busy, HI/LO read data, divide-by-zero pulse);
// slave is the mirror image.
interface alu_mdu_ctrl_if #(
  parameter int NB_DATA        = 32,
  parameter int NB_CTRL_OPCODE = 6,
  parameter int NB_ALU_OPCODE  = 4,
  parameter int NB_ALU_OP_SEL  = 2
) ();
  logic                      i_valid;
  logic [NB_ALU_OP_SEL-1:0]  i_operation;
  logic [NB_CTRL_OPCODE-1:0] i_ctrl_opcode;
  logic [NB_DATA-1:0]        i_data_a;
  logic [NB_DATA-1:0]        i_data_b;
  logic [NB_ALU_OPCODE-1:0]  o_alu_opcode;
  logic                      o_second_ope_sa;
  logic                      o_first_ope_rt;
  logic                      o_stall;
  logic                      o_busy;
  logic [NB_DATA-1:0]        o_hilo_data;
  logic                      o_hilo_valid;
  logic                      o_div_by_zero;
  modport master (
    output i_valid, i_operation, i_ctrl_opcode, i_data_a, i_data_b,
    input  o_alu_opcode, o_second_ope_sa, o_first_ope_rt, o_stall, o_busy,
           o_hilo_data, o_hilo_valid, o_div_by_zero
  );
  modport slave (
    input  i_valid, i_operation, i_ctrl_opcode, i_data_a, i_data_b,
    output o_alu_opcode, o_second_ope_sa, o_first_ope_rt, o_stall, o_busy,
           o_hilo_data, o_hilo_valid, o_div_by_zero
  );
endinterface

// File: rtl/alu_mdu_ctrl.sv
// alu_mdu_ctrl: ALU opcode/operand-select decode plus iterative MUL/DIV unit with HI/LO.
// Ports: i_clock, i_reset (sync, active-high); bus (alu_mdu_ctrl_if.slave) carries
// the EX-stage request and the decode, stall, busy, HI/LO read and div-by-zero outputs.
module alu_mdu_ctrl #(
  parameter int NB_DATA        = 32,
  parameter int NB_CTRL_OPCODE = 6,
  parameter int NB_ALU_OPCODE  = 4,
  parameter int NB_ALU_OP_SEL  = 2,
  parameter int NB_COUNT       = $clog2(NB_DATA+1)
) (
  input logic          i_clock,
  input logic          i_reset,
  alu_mdu_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t state_q, state_d;
  logic [NB_COUNT-1:0] cnt_q, cnt_d;
  logic [NB_DATA-1:0] hi_q, hi_d, lo_q, lo_d, p_hi_q, p_hi_d, p_lo_q, p_lo_d, m_q, m_d;
  logic neg_q, neg_d, rneg_q, rneg_d, div_q, div_d, dbz_q, dbz_d;
  logic [NB_ALU_OPCODE-1:0] alu_op;
  logic [5:0] f;
  logic [NB_DATA-1:0] a, b, abs_a, abs_b;
  logic is_mfmt, is_muldiv, req, busy, acc, a_neg, b_neg, ge;
  logic [NB_DATA:0] mul_t, shifted, dif;
  logic [2*NB_DATA-1:0] prod, prod_n;
  assign alu_op = bus.i_operation == 2'b00 ? bus.i_ctrl_opcode[NB_ALU_OPCODE-1:0] :
                  bus.i_operation == 2'b10 ? 4'b1011 : 4'b1100;
  assign bus.o_alu_opcode    = alu_op;
  assign bus.o_second_ope_sa = alu_op inside {4'b0000, 4'b0010, 4'b0011};
  assign bus.o_first_ope_rt  = alu_op inside {4'b1010, 4'b0110, 4'b0001};
  assign f         = bus.i_ctrl_opcode[5:0];
  assign a         = bus.i_data_a;
  assign b         = bus.i_data_b;
  // 0100xx = MFHI/MTHI/MFLO/MTLO, 0110xx = MULT/MULTU/DIV/DIVU; bit0 = unsigned for mul/div
  assign is_mfmt   = f[5:2] == 4'b0100;
  assign is_muldiv = f[5:2] == 4'b0110;
  assign req       = bus.i_valid & (bus.i_operation == 2'b11) & (is_mfmt | is_muldiv);
  assign busy      = state_q != IDLE;
  assign acc       = req & ~busy;
  assign bus.o_busy        = busy;
  assign bus.o_stall       = req & busy;
  assign bus.o_hilo_valid  = acc & is_mfmt & ~f[0];
  assign bus.o_hilo_data   = bus.o_hilo_valid ? (f[1] ? lo_q : hi_q) : '0;
  assign bus.o_div_by_zero = dbz_q;
  assign a_neg = ~f[0] & a[NB_DATA-1];
  assign b_neg = ~f[0] & b[NB_DATA-1];
  assign abs_a = a_neg ? -a : a;
  assign abs_b = b_neg ? -b : b;
  // Shift-add step: p_hi accumulates, p_lo holds the remaining multiplier bits
  assign mul_t   = p_lo_q[0] ? {1'b0, p_hi_q} + {1'b0, m_q} : {1'b0, p_hi_q};
  // Restoring step: p_hi is the partial remainder, p_lo shifts dividend out and quotient in
  assign shifted = {p_hi_q, p_lo_q[NB_DATA-1]};
  assign ge      = shifted >= {1'b0, m_q};
  assign dif     = shifted - {1'b0, m_q};
  assign prod    = {p_hi_q, p_lo_q};
  assign prod_n  = neg_q ? -prod : prod;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    m_d     = m_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    div_d   = div_q;
    dbz_d   = 1'b0;
    if (acc && is_muldiv && f[1] && b == '0) begin
      hi_d  = a;
      lo_d  = '1;
      dbz_d = 1'b1;
    end else if (acc && is_muldiv) begin
      state_d = f[1] ? DIV : MUL;
      cnt_d   = NB_COUNT'(NB_DATA);
      div_d   = f[1];
      neg_d   = a_neg ^ b_neg;
      rneg_d  = a_neg;
      m_d     = f[1] ? abs_b : abs_a;
      p_lo_d  = f[1] ? abs_a : abs_b;
      p_hi_d  = '0;
    end else if (acc && is_mfmt && f[0]) begin
      hi_d = f[1] ? hi_q : a;
      lo_d = f[1] ? a : lo_q;
    end else if (state_q == MUL || state_q == DIV) begin
      cnt_d   = cnt_q - NB_COUNT'(1);
      state_d = cnt_q == NB_COUNT'(1) ? FIX : state_q;
      p_hi_d  = state_q == DIV ? (ge ? dif[NB_DATA-1:0] : shifted[NB_DATA-1:0]) : mul_t[NB_DATA:1];
      p_lo_d  = state_q == DIV ? {p_lo_q[NB_DATA-2:0], ge} : {mul_t[0], p_lo_q[NB_DATA-1:1]};
    end else if (state_q == FIX) begin
      state_d = IDLE;
      hi_d    = div_q ? (rneg_q ? -p_hi_q : p_hi_q) : prod_n[2*NB_DATA-1:NB_DATA];
      lo_d    = div_q ? (neg_q ? -p_lo_q : p_lo_q) : prod_n[NB_DATA-1:0];
    end
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      m_q     <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      div_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      m_q     <= m_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      div_q   <= div_d;
      dbz_q   <= dbz_d;
    end
  end
endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// tb_alu_mdu_ctrl: directed self-checking bench with a HI/LO scoreboard.
module tb_alu_mdu_ctrl;
  localparam int N = 32;
  localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001, MFLO = 6'b010010, MTLO = 6'b010011;
  localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIVS = 6'b011010, DIVU = 6'b011011;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errs = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  always #5 clk = ~clk;
  alu_mdu_ctrl_if #(.NB_DATA(N), .NB_CTRL_OPCODE(6), .NB_ALU_OPCODE(4), .NB_ALU_OP_SEL(2)) bus ();
  alu_mdu_ctrl #(.NB_DATA(N), .NB_CTRL_OPCODE(6), .NB_ALU_OPCODE(4), .NB_ALU_OP_SEL(2)) dut (
    .i_clock(clk), .i_reset(rst), .bus(bus)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    bus.i_valid = v;
    bus.i_operation = op;
    bus.i_ctrl_opcode = f;
    bus.i_data_a = a;
    bus.i_data_b = b;
    #1;
  endtask
  task automatic idle();
    drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
  endtask
  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    logic signed [63:0] sa, sb, p;
    logic [63:0] u;
    sa = 64'($signed(a));
    sb = 64'($signed(b));
    hi = 32'd0;
    lo = 32'd0;
    if (f == MULT) begin
      p = sa * sb;
      {hi, lo} = p;
    end else if (f == MULTU) begin
      u = {32'd0, a} * {32'd0, b};
      {hi, lo} = u;
    end else if (b == 32'd0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
    end else if (f == DIVS) begin
      p = sa / sb;
      lo = p[31:0];
      p = sa % sb;
      hi = p[31:0];
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction
  task automatic push_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] h, l;
    model(f, a, b, h, l);
    exp_q.push_back(h);
    exp_q.push_back(l);
  endtask
  task automatic read_one(input logic [5:0] f, input string tag);
    int k = 0;
    drive(1'b1, 2'b11, f, 32'd0, 32'd0);
    while (!bus.o_hilo_valid && k < 100) begin
      k++;
      step();
    end
    chk({tag, "_valid"}, 64'(bus.o_hilo_valid), 64'd1);
    chk(tag, 64'(bus.o_hilo_data), 64'(exp_q.size() > 0 ? exp_q.pop_front() : 32'hDEAD_BEEF));
    step();
    idle();
  endtask
  task automatic read_hilo(input string tag);
    read_one(MFHI, {tag, "_hi"});
    read_one(MFLO, {tag, "_lo"});
  endtask
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int exp_busy, input string tag);
    int k = 0;
    int n = 0;
    push_model(f, a, b);
    drive(1'b1, 2'b11, f, a, b);
    while (bus.o_stall && k < 100) begin
      k++;
      step();
    end
    chk({tag, "_accept"}, 64'(bus.o_stall), 64'd0);
    step();
    idle();
    while (bus.o_busy && n < 100) begin
      n++;
      step();
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'(exp_busy));
    read_hilo(tag);
  endtask
  initial begin
    int k, bad;
    idle();
    repeat (2) step();
    rst = 1'b0;
    chk("rst_busy", 64'(bus.o_busy), 64'd0);
    chk("rst_stall", 64'(bus.o_stall), 64'd0);
    chk("rst_dbz", 64'(bus.o_div_by_zero), 64'd0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    read_hilo("rst");
    drive(1'b1, 2'b00, 6'b000010, 32'd0, 32'd0);
    chk("dec_rtype_op", 64'(bus.o_alu_opcode), 64'h2);
    chk("dec_rtype_sa", 64'(bus.o_second_ope_sa), 64'd1);
    chk("dec_rtype_rt", 64'(bus.o_first_ope_rt), 64'd0);
    drive(1'b1, 2'b01, 6'b000010, 32'd0, 32'd0);
    chk("dec_ldst", 64'(bus.o_alu_opcode), 64'hC);
    chk("dec_ldst_sa", 64'(bus.o_second_ope_sa), 64'd0);
    drive(1'b1, 2'b10, 6'b000010, 32'd0, 32'd0);
    chk("dec_branch", 64'(bus.o_alu_opcode), 64'hB);
    drive(1'b1, 2'b00, 6'b001010, 32'd0, 32'd0);
    chk("dec_first_rt", 64'(bus.o_first_ope_rt), 64'd1);
    drive(1'b1, 2'b11, 6'b100000, 32'd0, 32'd0);
    chk("dec_mdu_op", 64'(bus.o_alu_opcode), 64'hC);
    chk("dec_mdu_nop_stall", 64'(bus.o_stall), 64'd0);
    step();
    chk("mdu_nop_busy", 64'(bus.o_busy), 64'd0);
    idle();
    run_op(MULT, 32'hFFFF_FFFD, 32'd7, 33, "mult_neg");
    run_op(MULTU, 32'hFFFF_FFFF, 32'd2, 33, "multu");
    run_op(DIVS, 32'hFFFF_FFF9, 32'd2, 33, "div_neg");
    run_op(DIVU, 32'd100, 32'd7, 33, "divu");
    run_op(DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 33, "div_min");
    push_model(DIVU, 32'h1234, 32'd0);
    drive(1'b1, 2'b11, DIVU, 32'h1234, 32'd0);
    step();
    idle();
    chk("dbz_pulse", 64'(bus.o_div_by_zero), 64'd1);
    chk("dbz_busy", 64'(bus.o_busy), 64'd0);
    step();
    chk("dbz_pulse_end", 64'(bus.o_div_by_zero), 64'd0);
    chk("dbz_busy2", 64'(bus.o_busy), 64'd0);
    read_hilo("dbz");
    push_model(MULT, 32'd5, 32'd6);
    drive(1'b1, 2'b11, MULT, 32'd5, 32'd6);
    step();
    idle();
    repeat (5) step();
    drive(1'b1, 2'b11, MFHI, 32'd0, 32'd0);
    chk("stall_mfhi", 64'(bus.o_stall), 64'd1);
    chk("stall_mfhi_noval", 64'(bus.o_hilo_valid), 64'd0);
    chk("stall_mfhi_data0", 64'(bus.o_hilo_data), 64'd0);
    drive(1'b1, 2'b00, 6'b100000, 32'd1, 32'd2);
    chk("stall_add", 64'(bus.o_stall), 64'd0);
    drive(1'b1, 2'b11, MULT, 32'd9, 32'd9);
    chk("stall_mult", 64'(bus.o_stall), 64'd1);
    drive(1'b1, 2'b11, MFHI, 32'd0, 32'd0);
    k = 0;
    bad = 0;
    while (bus.o_busy && k < 100) begin
      if (bus.o_stall !== 1'b1) bad++;
      k++;
      step();
    end
    chk("stall_window", 64'(bad), 64'd0);
    chk("stall_release", 64'(bus.o_stall), 64'd0);
    chk("stall_wait_len", 64'(k), 64'd28);
    chk("stall_mfhi_valid", 64'(bus.o_hilo_valid), 64'd1);
    chk("stall_mfhi_data", 64'(bus.o_hilo_data), 64'(exp_q.pop_front()));
    step();
    idle();
    read_one(MFLO, "stall_mflo");
    drive(1'b1, 2'b11, MTLO, 32'hA5A5_A5A5, 32'd0);
    step();
    drive(1'b1, 2'b11, MTHI, 32'h1234_5678, 32'd0);
    step();
    idle();
    exp_q.push_back(32'h1234_5678);
    exp_q.push_back(32'hA5A5_A5A5);
    read_hilo("mt");
    drive(1'b1, 2'b11, DIVS, 32'd1000, 32'd3);
    step();
    idle();
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", 64'(bus.o_busy), 64'd0);
    drive(1'b1, 2'b11, MFHI, 32'd0, 32'd0);
    chk("midrst_stall", 64'(bus.o_stall), 64'd0);
    idle();
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    read_hilo("midrst");
    run_op(MULT, 32'd3, 32'd4, 33, "mult_after_rst");
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
